// File: rtl/seg_scan_if.sv
// Bus between a multiplexed 4-digit 7-segment driver tap and the scan decoder.
// Pulse outputs are single-cycle strobes with no back-pressure: frame_valid qualifies digits/changed for that cycle only.
interface seg_scan_if;
  logic [3:0]  anode_vec;
  logic [6:0]  cathode_vec;
  logic [15:0] digits;
  logic        frame_valid;
  logic        changed;
  logic        seg_err;
  logic        anode_err;
  logic        stale;

  modport master (
    output anode_vec, cathode_vec,
    input  digits, frame_valid, changed, seg_err, anode_err, stale
  );

  modport slave (
    input  anode_vec, cathode_vec,
    output digits, frame_valid, changed, seg_err, anode_err, stale
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers the four displayed digits from a scanned, active-low anode/cathode pair:
// debounces each dwell, decodes it into a shadow frame and publishes whole frames only.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic      clk,
  input  logic      rst,
  seg_scan_if.slave bus
);

  localparam logic [3:0]  STAB_MAX = 4'(STABLE_CYCLES);
  localparam logic [19:0] TO_MAX   = 20'(TIMEOUT_CYCLES);

  logic [3:0]  r_anode;
  logic [6:0]  r_cathode;
  logic [3:0]  r_prev_anode;
  logic [6:0]  r_prev_cathode;
  logic [3:0]  r_stab;
  logic        r_acc;
  logic [15:0] r_shadow;
  logic [3:0]  r_seen;
  logic [15:0] r_digits;
  logic        r_frame_valid;
  logic        r_changed;
  logic        r_seg_err;
  logic        r_anode_err;
  logic [19:0] r_to;
  logic        r_stale;

  logic        w_same;
  logic [3:0]  w_cnt;
  logic        w_hit;
  logic [2:0]  w_low_cnt;
  logic        w_accept;
  logic        w_anode_bad;
  logic [3:0]  w_nib;
  logic        w_seg_bad;
  logic        w_frame_done;
  logic [3:0]  w_seen_next;
  logic [15:0] w_shadow_next;
  logic [19:0] w_to_next;

  // w_cnt is the run length including the sample now in r_anode/r_cathode.
  assign w_same = ({r_anode, r_cathode} == {r_prev_anode, r_prev_cathode});
  assign w_cnt  = !w_same ? 4'd1 : ((r_stab >= STAB_MAX) ? STAB_MAX : r_stab + 4'd1);
  // A dwell is handled once; only a change of sample re-arms it.
  assign w_hit  = (w_cnt == STAB_MAX) && !(w_same && r_acc);

  assign w_low_cnt   = {2'b00, ~r_anode[0]} + {2'b00, ~r_anode[1]}
                     + {2'b00, ~r_anode[2]} + {2'b00, ~r_anode[3]};
  assign w_accept    = w_hit && (w_low_cnt == 3'd1);
  assign w_anode_bad = w_hit && (w_low_cnt >= 3'd2);

  always_comb begin
    w_nib     = 4'hE;
    w_seg_bad = 1'b1;
    case (r_cathode)
      7'h40: begin w_nib = 4'h0; w_seg_bad = 1'b0; end
      7'h79: begin w_nib = 4'h1; w_seg_bad = 1'b0; end
      7'h24: begin w_nib = 4'h2; w_seg_bad = 1'b0; end
      7'h30: begin w_nib = 4'h3; w_seg_bad = 1'b0; end
      7'h19: begin w_nib = 4'h4; w_seg_bad = 1'b0; end
      7'h12: begin w_nib = 4'h5; w_seg_bad = 1'b0; end
      7'h02: begin w_nib = 4'h6; w_seg_bad = 1'b0; end
      7'h78: begin w_nib = 4'h7; w_seg_bad = 1'b0; end
      7'h00: begin w_nib = 4'h8; w_seg_bad = 1'b0; end
      7'h10: begin w_nib = 4'h9; w_seg_bad = 1'b0; end
      7'h7F: begin w_nib = 4'hF; w_seg_bad = 1'b0; end
      default: begin w_nib = 4'hE; w_seg_bad = 1'b1; end
    endcase
  end

  // Completion clears seen, but a digit accepted in the same cycle still lands.
  assign w_frame_done = (r_seen == 4'hF);
  assign w_seen_next  = (w_frame_done ? 4'h0 : r_seen) | (w_accept ? ~r_anode : 4'h0);

  always_comb begin
    w_shadow_next = r_shadow;
    if (w_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (!r_anode[i]) w_shadow_next[i*4 +: 4] = w_nib;
      end
    end
  end

  assign w_to_next = w_accept ? 20'd0 : ((r_to == TO_MAX) ? TO_MAX : r_to + 20'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_anode        <= 4'hF;
      r_cathode      <= 7'h7F;
      r_prev_anode   <= 4'hF;
      r_prev_cathode <= 7'h7F;
      r_stab         <= 4'd0;
      r_acc          <= 1'b0;
      r_shadow       <= 16'hFFFF;
      r_seen         <= 4'h0;
      r_digits       <= 16'hFFFF;
      r_frame_valid  <= 1'b0;
      r_changed      <= 1'b0;
      r_seg_err      <= 1'b0;
      r_anode_err    <= 1'b0;
      r_to           <= 20'd0;
      r_stale        <= 1'b0;
    end else begin
      r_anode        <= bus.anode_vec;
      r_cathode      <= bus.cathode_vec;
      r_prev_anode   <= r_anode;
      r_prev_cathode <= r_cathode;
      r_stab         <= w_cnt;
      r_acc          <= w_hit || (w_same && r_acc);
      r_shadow       <= w_shadow_next;
      r_seen         <= w_seen_next;
      r_frame_valid  <= w_frame_done;
      r_changed      <= w_frame_done && (r_shadow != r_digits);
      if (w_frame_done) r_digits <= r_shadow;
      r_seg_err      <= w_accept && w_seg_bad;
      r_anode_err    <= w_anode_bad;
      r_to           <= w_to_next;
      // Stale is released only by a published frame, never by a lone digit.
      if (w_frame_done)             r_stale <= 1'b0;
      else if (w_to_next == TO_MAX) r_stale <= 1'b1;
    end
  end

  assign bus.digits      = r_digits;
  assign bus.frame_valid = r_frame_valid;
  assign bus.changed     = r_changed;
  assign bus.seg_err     = r_seg_err;
  assign bus.anode_err   = r_anode_err;
  assign bus.stale       = r_stale;

endmodule
